// File: rtl/wdt_pkg.sv
// Shared definitions for the windowed watchdog: config register bit map and reset causes.
package wdt_pkg;

  localparam int unsigned CFG_EN     = 0;
  localparam int unsigned CFG_OVF    = 1;
  localparam int unsigned CFG_TRAP   = 2;
  localparam int unsigned CFG_EARLY  = 3;
  localparam int unsigned CFG_IRQ_EN = 4;
  localparam int unsigned CFG_LOCK   = 5;
  localparam int unsigned CFG_WARN   = 6;

  typedef enum logic [1:0] {
    CAUSE_OVF,
    CAUSE_TRAP,
    CAUSE_EARLY
  } cause_e;

  function automatic int unsigned cause_bit(input cause_e c);
    case (c)
      CAUSE_OVF:   return CFG_OVF;
      CAUSE_TRAP:  return CFG_TRAP;
      default:     return CFG_EARLY;
    endcase
  endfunction

endpackage

// File: rtl/wdt_prescaler.sv
// Free-running prescaler; emits a one-cycle tick each time it wraps back to zero.
module wdt_prescaler #(
  parameter int unsigned PRESC_BITS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  logic [PRESC_BITS-1:0] count_q;
  logic [PRESC_BITS-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      count_d = count_q + 1'b1;
    end
  end

  assign tick = run & ~clear & (&count_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/windowed_watchdog.sv
// Windowed watchdog: counter with kick window, warning interrupt, lock bit and reset-cause flags.
module windowed_watchdog
  import wdt_pkg::*;
#(
  parameter  int unsigned WIDTH      = 16,
  parameter  int unsigned PRESC_BITS = 4,
  localparam int unsigned BYTES      = WIDTH / 8
) (
  input  logic             clk,
  input  logic             power_on_reset_n,
  input  logic             trap,
  input  logic             kick,
  output logic             reset,
  output logic             irq,
  input  logic [WIDTH-1:0] counter_in,
  output logic [WIDTH-1:0] counter_out,
  input  logic [BYTES-1:0] counter_write,
  input  logic [WIDTH-1:0] reload_in,
  output logic [WIDTH-1:0] reload_out,
  input  logic [BYTES-1:0] reload_write,
  input  logic [WIDTH-1:0] window_in,
  output logic [WIDTH-1:0] window_out,
  input  logic [BYTES-1:0] window_write,
  input  logic [WIDTH-1:0] warn_in,
  output logic [WIDTH-1:0] warn_out,
  input  logic [BYTES-1:0] warn_write,
  input  logic [7:0]       config_in,
  output logic [7:0]       config_out,
  input  logic             config_write
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic [WIDTH-1:0] win_q, win_d;
  logic [WIDTH-1:0] wrn_q, wrn_d;
  logic [7:0]       cfg_q, cfg_d;
  logic             fire_q, fire_d;

  logic int_rst;
  logic kick_ok;
  logic presc_run;
  logic presc_clear;
  logic tick;
  logic set_ovf, set_early, set_warn;

  assign reset       = ~power_on_reset_n | fire_q | trap;
  assign int_rst     = fire_q | trap;
  assign kick_ok     = kick & cfg_q[CFG_EN] & ~int_rst & (cnt_q >= win_q);
  assign presc_run   = cfg_q[CFG_EN] & ~reset;
  assign presc_clear = ~presc_run | kick_ok;

  wdt_prescaler #(
    .PRESC_BITS(PRESC_BITS)
  ) u_presc (
    .clk   (clk),
    .rst_n (power_on_reset_n),
    .run   (presc_run),
    .clear (presc_clear),
    .tick  (tick)
  );

  always_comb begin
    cnt_d     = cnt_q;
    rld_d     = rld_q;
    win_d     = win_q;
    wrn_d     = wrn_q;
    cfg_d     = cfg_q;
    fire_d    = 1'b0;
    set_ovf   = 1'b0;
    set_early = 1'b0;
    set_warn  = 1'b0;

    if (int_rst) begin
      // Reset in progress: register writes are dropped, only the trap cause can be added.
      cfg_d[CFG_EN]     = 1'b0;
      cfg_d[CFG_IRQ_EN] = 1'b0;
      cfg_d[CFG_LOCK]   = 1'b0;
      cfg_d[CFG_WARN]   = 1'b0;
      cnt_d             = rld_q;
      if (trap) begin
        cfg_d[cause_bit(CAUSE_TRAP)] = 1'b1;
      end
    end else begin
      if (kick && cfg_q[CFG_EN]) begin
        if (kick_ok) begin
          cnt_d           = rld_q;
          cfg_d[CFG_WARN] = 1'b0;
        end else begin
          fire_d    = 1'b1;
          set_early = 1'b1;
        end
      end else if (tick) begin
        if (&cnt_q) begin
          fire_d  = 1'b1;
          set_ovf = 1'b1;
          cnt_d   = rld_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        set_warn = (cnt_d == wrn_q);
      end

      for (int unsigned b = 0; b < BYTES; b++) begin
        if (counter_write[b]) begin
          cnt_d[8*b +: 8] = counter_in[8*b +: 8];
        end
        if (!cfg_q[CFG_LOCK]) begin
          if (reload_write[b]) rld_d[8*b +: 8] = reload_in[8*b +: 8];
          if (window_write[b]) win_d[8*b +: 8] = window_in[8*b +: 8];
          if (warn_write[b])   wrn_d[8*b +: 8] = warn_in[8*b +: 8];
        end
      end

      if (config_write) begin
        if (!cfg_q[CFG_LOCK]) begin
          cfg_d[CFG_EN]     = config_in[CFG_EN];
          cfg_d[CFG_IRQ_EN] = config_in[CFG_IRQ_EN];
          cfg_d[CFG_LOCK]   = config_in[CFG_LOCK];
        end
        cfg_d[CFG_OVF]   = cfg_d[CFG_OVF]   & ~config_in[CFG_OVF];
        cfg_d[CFG_TRAP]  = cfg_d[CFG_TRAP]  & ~config_in[CFG_TRAP];
        cfg_d[CFG_EARLY] = cfg_d[CFG_EARLY] & ~config_in[CFG_EARLY];
        cfg_d[CFG_WARN]  = cfg_d[CFG_WARN]  & ~config_in[CFG_WARN];
      end

      // Sets are applied after W1C so a same-cycle set wins.
      if (set_ovf)   cfg_d[cause_bit(CAUSE_OVF)]   = 1'b1;
      if (set_early) cfg_d[cause_bit(CAUSE_EARLY)] = 1'b1;
      if (set_warn)  cfg_d[CFG_WARN]               = 1'b1;
    end

    cfg_d[7] = 1'b0;
  end

  always_ff @(posedge clk or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      cnt_q  <= '0;
      rld_q  <= '0;
      win_q  <= '0;
      wrn_q  <= '0;
      cfg_q  <= '0;
      fire_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rld_q  <= rld_d;
      win_q  <= win_d;
      wrn_q  <= wrn_d;
      cfg_q  <= cfg_d;
      fire_q <= fire_d;
    end
  end

  assign counter_out = cnt_q;
  assign reload_out  = rld_q;
  assign window_out  = win_q;
  assign warn_out    = wrn_q;
  assign config_out  = cfg_q;
  assign irq         = cfg_q[CFG_WARN] & cfg_q[CFG_IRQ_EN];

endmodule

// File: tb/tb_windowed_watchdog.sv
// Directed self-checking bench for windowed_watchdog (WIDTH=16, PRESC_BITS=4).
module tb_windowed_watchdog;

  logic        clk;
  logic        power_on_reset_n;
  logic        trap;
  logic        kick;
  logic        reset;
  logic        irq;
  logic [15:0] counter_in, counter_out, reload_in, reload_out;
  logic [15:0] window_in, window_out, warn_in, warn_out;
  logic [1:0]  counter_write, reload_write, window_write, warn_write;
  logic [7:0]  config_in, config_out;
  logic        config_write;

  int checks   = 0;
  int failures = 0;

  windowed_watchdog #(
    .WIDTH(16),
    .PRESC_BITS(4)
  ) dut (
    .clk              (clk),
    .power_on_reset_n (power_on_reset_n),
    .trap             (trap),
    .kick             (kick),
    .reset            (reset),
    .irq              (irq),
    .counter_in       (counter_in),
    .counter_out      (counter_out),
    .counter_write    (counter_write),
    .reload_in        (reload_in),
    .reload_out       (reload_out),
    .reload_write     (reload_write),
    .window_in        (window_in),
    .window_out       (window_out),
    .window_write     (window_write),
    .warn_in          (warn_in),
    .warn_out         (warn_out),
    .warn_write       (warn_write),
    .config_in        (config_in),
    .config_out       (config_out),
    .config_write     (config_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_cfg(input logic [7:0] v);
    config_in = v; config_write = 1'b1;
    step(1);
    config_write = 1'b0;
  endtask

  task automatic wr_counter(input logic [15:0] v);
    counter_in = v; counter_write = '1;
    step(1);
    counter_write = '0;
  endtask

  task automatic wr_reload(input logic [15:0] v);
    reload_in = v; reload_write = '1;
    step(1);
    reload_write = '0;
  endtask

  task automatic wr_window(input logic [15:0] v);
    window_in = v; window_write = '1;
    step(1);
    window_write = '0;
  endtask

  task automatic wr_warn(input logic [15:0] v);
    warn_in = v; warn_write = '1;
    step(1);
    warn_write = '0;
  endtask

  task automatic do_kick();
    kick = 1'b1;
    step(1);
    kick = 1'b0;
  endtask

  initial begin
    power_on_reset_n = 1'b0;
    trap = 1'b0; kick = 1'b0;
    counter_in = '0; reload_in = '0; window_in = '0; warn_in = '0; config_in = '0;
    counter_write = '0; reload_write = '0; window_write = '0; warn_write = '0;
    config_write = 1'b0;

    #12;
    chk("por_reset", reset, 1);
    chk("por_irq", irq, 0);
    chk("por_cfg", config_out, 8'h00);
    chk("por_cnt", counter_out, 16'h0000);
    power_on_reset_n = 1'b1;
    step(1);
    chk("rel_reset", reset, 0);

    // 1. overflow from FFFE with reload FFF0
    wr_reload(16'hFFF0);
    wr_counter(16'hFFFE);
    wr_cfg(8'h01);
    step(15);
    chk("t1_cnt_pre", counter_out, 16'hFFFE);
    step(1);
    chk("t1_first_tick", counter_out, 16'hFFFF);
    step(15);
    chk("t1_no_reset_yet", reset, 0);
    step(1);
    chk("t1_fire", reset, 1);
    chk("t1_cnt_wrap", counter_out, 16'hFFF0);
    step(1);
    chk("t1_pulse_end", reset, 0);
    chk("t1_cfg", config_out, 8'h02);
    chk("t1_cnt", counter_out, 16'hFFF0);
    wr_cfg(8'h02);
    chk("t1_w1c", config_out, 8'h00);

    // 2. early kick, then boundary kick at counter == window
    wr_window(16'h0100);
    wr_counter(16'h0080);
    wr_cfg(8'h01);
    do_kick();
    chk("t2_early_fire", reset, 1);
    step(1);
    chk("t2_early_end", reset, 0);
    chk("t2_cfg", config_out, 8'h08);
    chk("t2_cnt", counter_out, 16'hFFF0);
    wr_cfg(8'h08);
    wr_reload(16'h0200);
    wr_counter(16'h0100);
    wr_cfg(8'h01);
    do_kick();
    chk("t2_ok_reset", reset, 0);
    chk("t2_ok_cnt", counter_out, 16'h0200);
    chk("t2_ok_cfg", config_out, 8'h01);
    wr_cfg(8'h00);

    // 3. warning interrupt
    wr_window(16'h0000);
    wr_warn(16'h0010);
    wr_counter(16'h000F);
    wr_cfg(8'h11);
    step(15);
    chk("t3_irq_pre", irq, 0);
    step(1);
    chk("t3_cnt", counter_out, 16'h0010);
    chk("t3_irq", irq, 1);
    chk("t3_cfg", config_out, 8'h51);
    do_kick();
    chk("t3_kick_irq", irq, 0);
    chk("t3_kick_cnt", counter_out, 16'h0200);
    wr_counter(16'h000F);
    step(15);
    chk("t3_irq_again", irq, 1);
    wr_cfg(8'h40);
    chk("t3_w1c_irq", irq, 0);
    chk("t3_w1c_cfg", config_out, 8'h00);

    // 4. lock, then trap with simultaneous W1C of TRAP
    wr_cfg(8'h21);
    wr_cfg(8'h00);
    chk("t4_lock_cfg", config_out, 8'h21);
    wr_reload(16'h1234);
    chk("t4_lock_reload", reload_out, 16'h0200);
    trap = 1'b1; config_in = 8'h04; config_write = 1'b1;
    #1;
    chk("t4_trap_comb", reset, 1);
    step(1);
    trap = 1'b0; config_write = 1'b0;
    #1;
    chk("t4_trap_cfg", config_out, 8'h04);
    chk("t4_trap_cnt", counter_out, 16'h0200);
    chk("t4_trap_reset_end", reset, 0);
    wr_cfg(8'h04);

    // 5. kick coincident with FFFF overflow tick
    wr_reload(16'h0300);
    wr_counter(16'hFFFF);
    wr_cfg(8'h01);
    step(15);
    do_kick();
    chk("t5_reset", reset, 0);
    chk("t5_cnt", counter_out, 16'h0300);
    chk("t5_cfg", config_out, 8'h01);
    step(1);
    chk("t5_reset_next", reset, 0);

    // 6. asynchronous POR mid-count with a cause bit set
    trap = 1'b1;
    step(1);
    trap = 1'b0;
    wr_cfg(8'h01);
    chk("t6_cfg_pre", config_out, 8'h05);
    wr_counter(16'h1000);
    step(20);
    #2;
    power_on_reset_n = 1'b0;
    #1;
    chk("t6_reset", reset, 1);
    chk("t6_irq", irq, 0);
    chk("t6_cfg", config_out, 8'h00);
    chk("t6_cnt", counter_out, 16'h0000);
    chk("t6_reload", reload_out, 16'h0000);
    #10;
    power_on_reset_n = 1'b1;
    step(2);
    chk("t6_cfg_after", config_out, 8'h00);
    chk("t6_reset_after", reset, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
